// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state and variable codes for the CORDIC sine/cosine control FSM
//   state_t            : controller states, one per clock
//   VAR_X/VAR_Y/VAR_Z  : variable-counter codes selecting which of X/Y/Z is being updated
package cordic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        MUX,
        SHIFT,
        ADD_GO,
        ADD_WAIT,
        NEXT_ITER,
        OUT_SEL,
        OUT_REG,
        DONE
    } state_t;

    localparam logic [1:0] VAR_X = 2'b00;
    localparam logic [1:0] VAR_Y = 2'b01;
    localparam logic [1:0] VAR_Z = 2'b10;

endpackage

// File: rtl/cordic_fsm_ctrl_if.sv
// cordic_fsm_ctrl_if: start/ready/ack handshake between the CORDIC controller and its consumer
//   beg_FSM_CORDIC : consumer -> controller, start request
//   ACK_FSM_CORDIC : consumer -> controller, result taken
//   ready_CORDIC   : controller -> consumer, result valid (held until ACK)
//   master = consumer side, slave = controller side
interface cordic_fsm_ctrl_if;

    logic beg_FSM_CORDIC;
    logic ACK_FSM_CORDIC;
    logic ready_CORDIC;

    modport master (output beg_FSM_CORDIC, output ACK_FSM_CORDIC, input ready_CORDIC);
    modport slave (input beg_FSM_CORDIC, input ACK_FSM_CORDIC, output ready_CORDIC);

endinterface

// File: rtl/cordic_fsm_ctrl.sv
// cordic_fsm_ctrl: control FSM sequencing capture, X/Y/Z iterations and output selection of the CORDIC unit
//   clk, reset          : clock and synchronous active-high reset
//   hs                  : consumer handshake (beg/ACK in, ready out)
//   operation           : 0 = cosine, 1 = sine
//   shift_region_flag   : angle region; 01/10 mean the angle was shifted by +/-pi/2
//   cont_var            : variable counter (00 X, 01 Y, 10 Z)
//   ready_add_subt      : add/sub result valid
//   max/min_tick_iter   : iteration counter at last/first count
//   max/min_tick_var    : variable counter at last/first count
//   beg/ack_add_subt    : add/sub start and result-taken pulses
//   sel_mux_1..3, mode  : datapath mux selects and CORDIC mode (rotation only)
//   enab_*/load_*       : counter controls and datapath register enables
module cordic_fsm_ctrl
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    cordic_fsm_ctrl_if.slave hs,
    input  logic             operation,
    input  logic [1:0]       shift_region_flag,
    input  logic [1:0]       cont_var,
    input  logic             ready_add_subt,
    input  logic             max_tick_iter,
    input  logic             min_tick_iter,
    input  logic             max_tick_var,
    input  logic             min_tick_var,
    output logic             beg_add_subt,
    output logic             ack_add_subt,
    output logic             sel_mux_1,
    output logic [1:0]       sel_mux_2,
    output logic             sel_mux_3,
    output logic             mode,
    output logic             enab_cont_iter,
    output logic             load_cont_iter,
    output logic             enab_cont_var,
    output logic             load_cont_var,
    output logic             enab_RB1,
    output logic             enab_RB2,
    output logic             enab_d_ff_Xn,
    output logic             enab_d_ff_Yn,
    output logic             enab_d_ff_Zn,
    output logic             enab_dff5,
    output logic             enab_d_ff_out,
    output logic             enab_dff_shifted_x,
    output logic             enab_dff_shifted_y,
    output logic             enab_dff_LUT,
    output logic             enab_dff_sign
);

    state_t state, next;
    logic   unused_min_tick_var;

    // the transitions never need the first-count flag of the variable counter
    assign unused_min_tick_var = min_tick_var;

    // a +/-pi/2 region shift swaps the roles of X and Y at the output
    assign sel_mux_3 = operation ^ (shift_region_flag == 2'b01 || shift_region_flag == 2'b10);
    assign mode      = 1'b0;

    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    always_comb begin
        next               = state;
        hs.ready_CORDIC    = 1'b0;
        beg_add_subt       = 1'b0;
        ack_add_subt       = 1'b0;
        sel_mux_1          = 1'b0;
        sel_mux_2          = 2'b00;
        enab_cont_iter     = 1'b0;
        load_cont_iter     = 1'b0;
        enab_cont_var      = 1'b0;
        load_cont_var      = 1'b0;
        enab_RB1           = 1'b0;
        enab_RB2           = 1'b0;
        enab_d_ff_Xn       = 1'b0;
        enab_d_ff_Yn       = 1'b0;
        enab_d_ff_Zn       = 1'b0;
        enab_dff5          = 1'b0;
        enab_d_ff_out      = 1'b0;
        enab_dff_shifted_x = 1'b0;
        enab_dff_shifted_y = 1'b0;
        enab_dff_LUT       = 1'b0;
        enab_dff_sign      = 1'b0;
        case (state)
            IDLE: next = hs.beg_FSM_CORDIC ? LOAD : IDLE;
            LOAD: begin
                enab_RB1       = 1'b1;
                load_cont_iter = 1'b1;
                load_cont_var  = 1'b1;
                next           = MUX;
            end
            MUX: begin
                enab_RB2  = 1'b1;
                // first iteration takes the captured inputs, later ones the fed-back results
                sel_mux_1 = ~min_tick_iter;
                next      = SHIFT;
            end
            SHIFT: begin
                enab_dff_shifted_x = 1'b1;
                enab_dff_shifted_y = 1'b1;
                enab_dff_LUT       = 1'b1;
                enab_dff_sign      = 1'b1;
                next               = ADD_GO;
            end
            ADD_GO: begin
                beg_add_subt = 1'b1;
                sel_mux_2    = cont_var;
                next         = ADD_WAIT;
            end
            ADD_WAIT: begin
                sel_mux_2 = cont_var;
                if (ready_add_subt) begin
                    ack_add_subt  = 1'b1;
                    enab_cont_var = 1'b1;
                    enab_d_ff_Xn  = cont_var == VAR_X;
                    enab_d_ff_Yn  = cont_var == VAR_Y;
                    enab_d_ff_Zn  = cont_var == VAR_Z;
                    next          = max_tick_var ? NEXT_ITER : ADD_GO;
                end
            end
            NEXT_ITER: begin
                enab_cont_iter = ~max_tick_iter;
                load_cont_var  = ~max_tick_iter;
                next           = max_tick_iter ? OUT_SEL : MUX;
            end
            OUT_SEL: begin
                enab_dff5 = 1'b1;
                next      = OUT_REG;
            end
            OUT_REG: begin
                enab_d_ff_out = 1'b1;
                next          = DONE;
            end
            DONE: begin
                hs.ready_CORDIC = 1'b1;
                next            = hs.ACK_FSM_CORDIC ? IDLE : DONE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cordic_fsm_ctrl.sv
// tb_cordic_fsm_ctrl: scoreboard bench for the CORDIC control FSM, one expected output word per cycle
module tb_cordic_fsm_ctrl;

    typedef logic [22:0] word_t;
    typedef logic [11:0] stim_t;

    localparam word_t RDY  = word_t'(1) << 22;
    localparam word_t BEG  = word_t'(1) << 21;
    localparam word_t ACK  = word_t'(1) << 20;
    localparam word_t S1   = word_t'(1) << 19;
    localparam word_t SL2Y = word_t'(1) << 17;
    localparam word_t SL2Z = word_t'(2) << 17;
    localparam word_t S3   = word_t'(1) << 16;
    localparam word_t ECI  = word_t'(1) << 14;
    localparam word_t LCI  = word_t'(1) << 13;
    localparam word_t ECV  = word_t'(1) << 12;
    localparam word_t LCV  = word_t'(1) << 11;
    localparam word_t RB1  = word_t'(1) << 10;
    localparam word_t RB2  = word_t'(1) << 9;
    localparam word_t XN   = word_t'(1) << 8;
    localparam word_t YN   = word_t'(1) << 7;
    localparam word_t ZN   = word_t'(1) << 6;
    localparam word_t D5   = word_t'(1) << 5;
    localparam word_t OUTR = word_t'(1) << 4;
    localparam word_t SHF  = word_t'(15);
    localparam word_t LOADW = RB1 | LCI | LCV;

    localparam stim_t S_RST = stim_t'(1) << 11;
    localparam stim_t S_BEG = stim_t'(1) << 10;
    localparam stim_t S_ACK = stim_t'(1) << 9;
    localparam stim_t S_RDY = stim_t'(1) << 8;
    localparam stim_t CV_Y  = stim_t'(1) << 6;
    localparam stim_t CV_Z  = stim_t'(2) << 6;
    localparam stim_t S_MXI = stim_t'(1) << 5;
    localparam stim_t S_MNI = stim_t'(1) << 4;
    localparam stim_t S_MXV = stim_t'(1) << 3;
    localparam stim_t S_OP  = stim_t'(1) << 2;
    localparam stim_t FL_01 = stim_t'(1);
    localparam stim_t FL_10 = stim_t'(2);
    localparam stim_t FL_11 = stim_t'(3);

    logic clk = 1'b0;
    logic reset, operation, ready_add_subt, max_tick_iter, min_tick_iter, max_tick_var, min_tick_var;
    logic [1:0] shift_region_flag, cont_var, sel_mux_2;
    logic beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_3, mode;
    logic enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var, enab_RB1, enab_RB2;
    logic enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff5, enab_d_ff_out;
    logic enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign;

    int checks = 0;
    int fails  = 0;
    word_t sb[$];

    cordic_fsm_ctrl_if hs ();

    cordic_fsm_ctrl dut (
        .clk(clk), .reset(reset), .hs(hs),
        .operation(operation), .shift_region_flag(shift_region_flag), .cont_var(cont_var),
        .ready_add_subt(ready_add_subt), .max_tick_iter(max_tick_iter), .min_tick_iter(min_tick_iter),
        .max_tick_var(max_tick_var), .min_tick_var(min_tick_var),
        .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
        .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2), .sel_mux_3(sel_mux_3), .mode(mode),
        .enab_cont_iter(enab_cont_iter), .load_cont_iter(load_cont_iter),
        .enab_cont_var(enab_cont_var), .load_cont_var(load_cont_var),
        .enab_RB1(enab_RB1), .enab_RB2(enab_RB2),
        .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
        .enab_dff5(enab_dff5), .enab_d_ff_out(enab_d_ff_out),
        .enab_dff_shifted_x(enab_dff_shifted_x), .enab_dff_shifted_y(enab_dff_shifted_y),
        .enab_dff_LUT(enab_dff_LUT), .enab_dff_sign(enab_dff_sign)
    );

    always #5 clk = ~clk;

    function automatic word_t outs();
        return {hs.ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_2, sel_mux_3, mode,
                enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var, enab_RB1, enab_RB2,
                enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff5, enab_d_ff_out,
                enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign};
    endfunction

    task automatic drive(input stim_t s);
        reset                = s[11];
        hs.beg_FSM_CORDIC    = s[10];
        hs.ACK_FSM_CORDIC    = s[9];
        ready_add_subt       = s[8];
        cont_var             = s[7:6];
        max_tick_iter        = s[5];
        min_tick_iter        = s[4];
        max_tick_var         = s[3];
        operation            = s[2];
        shift_region_flag    = s[1:0];
    endtask

    task automatic test_reset();
        stim_t s [4] = '{S_RST, 0, 0, 0};
        word_t e [4] = '{0, 0, 0, 0};
        word_t exp;
        foreach (s[i]) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            exp = sb.pop_front();
            checks++;
            if (outs() !== exp) begin
                fails++;
                $display("FAIL reset[%0d]: got %h expected %h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_start();
        stim_t s [5] = '{S_BEG | S_MNI, S_MNI, S_MNI, S_MNI, 0};
        word_t e [5] = '{0, LOADW, RB2, SHF, BEG};
        word_t exp;
        foreach (s[i]) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            exp = sb.pop_front();
            checks++;
            if (outs() !== exp) begin
                fails++;
                $display("FAIL start[%0d]: got %h expected %h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_add_wait();
        stim_t s [13] = '{0, 0, S_RDY, CV_Y, S_RDY | CV_Y, CV_Z, CV_Z, S_RDY | CV_Z | S_MXV,
                          0, 0, 0, 0, S_RDY | S_MXV};
        word_t e [13] = '{0, 0, ACK | ECV | XN, BEG | SL2Y, ACK | ECV | YN | SL2Y, BEG | SL2Z, SL2Z,
                          ACK | ECV | ZN | SL2Z, ECI | LCV, RB2 | S1, SHF, BEG, ACK | ECV | XN};
        word_t exp;
        foreach (s[i]) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            exp = sb.pop_front();
            checks++;
            if (outs() !== exp) begin
                fails++;
                $display("FAIL add_wait[%0d]: got %h expected %h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_output();
        stim_t s [8] = '{S_MXI, 0, 0, 0, S_BEG, S_ACK, 0, 0};
        word_t e [8] = '{0, D5, OUTR, RDY, RDY, RDY, 0, 0};
        word_t exp;
        foreach (s[i]) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            exp = sb.pop_front();
            checks++;
            if (outs() !== exp) begin
                fails++;
                $display("FAIL output[%0d]: got %h expected %h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_sel_mux_3();
        stim_t s [6] = '{S_OP | FL_01, 0, S_OP, FL_10, S_OP | FL_11, FL_11};
        word_t e [6] = '{0, 0, S3, S3, S3, 0};
        word_t exp;
        foreach (s[i]) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            exp = sb.pop_front();
            checks++;
            if (outs() !== exp) begin
                fails++;
                $display("FAIL sel_mux_3[%0d]: got %h expected %h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        stim_t s [10] = '{S_BEG | S_MNI, S_MNI, S_MNI, S_MNI, CV_Y, S_RST | CV_Y, 0,
                          S_BEG | S_MNI, S_MNI, S_MNI};
        word_t e [10] = '{0, LOADW, RB2, SHF, BEG | SL2Y, SL2Y, 0, 0, LOADW, RB2};
        word_t exp;
        foreach (s[i]) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            exp = sb.pop_front();
            checks++;
            if (outs() !== exp) begin
                fails++;
                $display("FAIL reset_abort[%0d]: got %h expected %h", i, outs(), exp);
            end
        end
    endtask

    initial begin
        min_tick_var = 1'b0;
        drive(S_RST);
        test_reset();
        test_start();
        test_add_wait();
        test_output();
        test_sel_mux_3();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
